// File: rtl/data_memory_pkg.sv
// Shared access-size codes, geometry defaults and byte-lane helper for the data memory.
// Controller and memory stage decode dm_op with the same dm_op_e values.
package data_memory_pkg;

    typedef enum logic [2:0] {
        DM_NONE   = 3'd0,
        DM_WORD   = 3'd1,
        DM_HALF   = 3'd2,
        DM_HALF_U = 3'd3,
        DM_BYTE   = 3'd4,
        DM_BYTE_U = 3'd5
    } dm_op_e;

    localparam int          DM_OP_BITS     = 3;
    localparam logic [31:0] DM_ADDR_BASE   = 32'h0000_0000;
    localparam int          DM_DEPTH_WORDS = 3072;

    // Lane mask for a store; unsigned variants write exactly like their signed twins.
    function automatic logic [3:0] dm_byte_en(input logic [2:0] op, input logic [1:0] off);
        logic [3:0] en;
        en = 4'b0000;
        case (op)
            DM_WORD:            en = 4'b1111;
            DM_HALF, DM_HALF_U: en = off[1] ? 4'b1100 : 4'b0011;
            DM_BYTE, DM_BYTE_U: en = 4'b0001 << off;
            default:            en = 4'b0000;
        endcase
        return en;
    endfunction

endpackage

// File: rtl/data_memory_load_ext.sv
// dm_load_ext: picks the addressed half/byte out of a word and sign- or zero-extends it.
// Purely combinational so a later pipelined MEM/WB stage can reuse it unchanged.
module dm_load_ext
    import data_memory_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_off,
    input  logic [2:0]  dm_op,
    output logic [31:0] rdata
);

    logic [15:0] half;
    logic [7:0]  byte_sel;

    assign half     = byte_off[1] ? word[31:16] : word[15:0];
    assign byte_sel = word[{byte_off, 3'b000} +: 8];

    always_comb begin
        rdata = '0;
        case (dm_op)
            DM_WORD:   rdata = word;
            DM_HALF:   rdata = {{16{half[15]}}, half};
            DM_HALF_U: rdata = {16'h0000, half};
            DM_BYTE:   rdata = {{24{byte_sel[7]}}, byte_sel};
            DM_BYTE_U: rdata = {24'h000000, byte_sel};
            default:   rdata = '0;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// data_memory: word-organised data memory with byte-enable stores, extended loads and sticky error capture.
// Optional macro DM_WRITE_TRACE_EN prints every committed store at its write edge.
module data_memory
    import data_memory_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = DM_ADDR_BASE,
    parameter int          DEPTH_WORDS = DM_DEPTH_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_write,
    input  logic [2:0]  dm_op,
    output logic [31:0] rdata,
    output logic        access_err,
    output logic        err_sticky,
    output logic [31:0] err_addr
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    logic [31:0]      mem [DEPTH_WORDS];
    logic [31:0]      offset;
    logic [IDX_W-1:0] index;
    logic             in_range;
    logic             op_valid;
    logic             misaligned;
    logic             do_store;
    logic [31:0]      cur_word;
    logic [31:0]      wlanes;
    logic [31:0]      merged;
    logic [3:0]       byte_en;
    logic [31:0]      ext_rdata;
    logic             unused_bits;

    assign offset   = addr - ADDR_BASE;
    assign index    = offset[IDX_W+1:2];
    assign in_range = (addr >= ADDR_BASE) && (addr < ADDR_BASE + 32'(4 * DEPTH_WORDS));
    assign cur_word = in_range ? mem[index] : '0;

    // pc only feeds the optional trace; the high offset bits are covered by the range check.
    assign unused_bits = ^{pc, offset[31:IDX_W+2], offset[1:0]};

    // DM_NONE (and undefined codes) never touch memory, so they can never be in error.
    always_comb begin
        op_valid   = 1'b0;
        misaligned = 1'b0;
        case (dm_op)
            DM_WORD: begin
                op_valid   = 1'b1;
                misaligned = (addr[1:0] != 2'b00);
            end
            DM_HALF, DM_HALF_U: begin
                op_valid   = 1'b1;
                misaligned = addr[0];
            end
            DM_BYTE, DM_BYTE_U: op_valid = 1'b1;
            default: ;
        endcase
    end

    assign access_err = op_valid && (!in_range || misaligned);
    assign do_store   = mem_write && op_valid && !access_err;
    assign byte_en    = dm_byte_en(dm_op, addr[1:0]);

    // Replicate the store data across lanes so the lane mask alone decides what lands where.
    always_comb begin
        wlanes = wdata;
        case (dm_op)
            DM_HALF, DM_HALF_U: wlanes = {2{wdata[15:0]}};
            DM_BYTE, DM_BYTE_U: wlanes = {4{wdata[7:0]}};
            default:            wlanes = wdata;
        endcase
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = byte_en[i] ? wlanes[8*i +: 8] : cur_word[8*i +: 8];
        end
    end

    dm_load_ext u_load_ext (
        .word     (cur_word),
        .byte_off (addr[1:0]),
        .dm_op    (dm_op),
        .rdata    (ext_rdata)
    );

    assign rdata = access_err ? 32'h0 : ext_rdata;

    // The first erroneous access after reset is latched; later errors leave it alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
            err_sticky <= 1'b0;
            err_addr   <= '0;
        end else begin
            if (do_store) begin
                mem[index] <= merged;
`ifdef DM_WRITE_TRACE_EN
                $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, merged);
`endif
            end
            if (access_err && !err_sticky) begin
                err_sticky <= 1'b1;
                err_addr   <= addr;
            end
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: directed vectors plus randomized traffic against a byte-array model.
module tb_data_memory;
    import data_memory_pkg::*;

    localparam int MEM_BYTES = 12288;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_write;
    logic [2:0]  dm_op;
    logic [31:0] rdata;
    logic        access_err;
    logic        err_sticky;
    logic [31:0] err_addr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  mb [MEM_BYTES];
    logic        m_sticky;
    logic [31:0] m_err_addr;

    data_memory dut (
        .clk        (clk),
        .reset      (reset),
        .pc         (pc),
        .addr       (addr),
        .wdata      (wdata),
        .mem_write  (mem_write),
        .dm_op      (dm_op),
        .rdata      (rdata),
        .access_err (access_err),
        .err_sticky (err_sticky),
        .err_addr   (err_addr)
    );

    always #5 clk = ~clk;

    // Reference model: a flat little-endian byte array addressed directly by byte address.
    function automatic logic m_err(input logic [31:0] a, input logic [2:0] op);
        if (op == 3'd0 || op > 3'd5) return 1'b0;
        if (a >= 32'h3000) return 1'b1;
        if (op == 3'd1) return (a % 4) != 0;
        if (op == 3'd2 || op == 3'd3) return (a % 2) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] op);
        if (m_err(a, op)) return 32'h0;
        case (op)
            3'd1: return {mb[a+3], mb[a+2], mb[a+1], mb[a]};
            3'd2: return {{16{mb[a+1][7]}}, mb[a+1], mb[a]};
            3'd3: return {16'h0, mb[a+1], mb[a]};
            3'd4: return {{24{mb[a][7]}}, mb[a]};
            3'd5: return {24'h0, mb[a]};
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_clear();
        for (int i = 0; i < MEM_BYTES; i++) mb[i] = 8'h00;
        m_sticky   = 1'b0;
        m_err_addr = 32'h0;
    endtask

    task automatic m_commit(input logic we, input logic [31:0] a, input logic [2:0] op, input logic [31:0] wd);
        int n;
        if (m_err(a, op) && !m_sticky) begin
            m_sticky   = 1'b1;
            m_err_addr = a;
        end
        if (we && op >= 3'd1 && op <= 3'd5 && !m_err(a, op)) begin
            n = (op == 3'd1) ? 4 : (op <= 3'd3) ? 2 : 1;
            for (int k = 0; k < n; k++) mb[a + 32'(k)] = wd[8*k +: 8];
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [2:0] op, input logic we, input logic [31:0] wd);
        @(negedge clk);
        addr      = a;
        dm_op     = op;
        mem_write = we;
        wdata     = wd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        m_commit(mem_write, addr, dm_op, wdata);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        mem_write = 1'b0;
        dm_op     = DM_NONE;
        reset     = 1'b0;
        m_clear();
        #2;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        m_clear();
        #3;
        n_checks++;
        if (err_sticky !== 1'b0 || err_addr !== 32'h0)
            begin n_fail++; $display("[TB] FAIL reset_regs: sticky=%b addr=%h required 0/0", err_sticky, err_addr); end
        #10 reset = 1'b1;
        drive(32'h0, DM_WORD, 1'b0, 32'h0);
        n_checks++;
        if (rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_lw0: got %h required 0", rdata); end
        drive(32'h2FFC, DM_WORD, 1'b0, 32'h0);
        n_checks++;
        if (rdata !== 32'h0 || access_err !== 1'b0)
            begin n_fail++; $display("[TB] FAIL reset_lw2ffc: got %h err=%b required 0/0", rdata, access_err); end
        tick();
        n_checks++;
        if (err_sticky !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_sticky: got %b required 0", err_sticky); end
    endtask

    task automatic test_loads_stores();
        logic [31:0] la [5] = '{32'h8, 32'h8, 32'hB, 32'hA, 32'h8};
        logic [2:0]  lo [5] = '{DM_WORD, DM_BYTE, DM_BYTE_U, DM_HALF, DM_HALF_U};
        logic [31:0] le [5] = '{32'h8899AABB, 32'hFFFFFFBB, 32'h00000088, 32'hFFFF8899, 32'h0000AABB};
        drive(32'h8, DM_WORD, 1'b1, 32'h8899AABB);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(la[i], lo[i], 1'b0, 32'h0);
            n_checks++;
            if (rdata !== le[i])
                begin n_fail++; $display("[TB] FAIL load_ext[%0d] addr=%h op=%0d: got %h required %h", i, la[i], lo[i], rdata, le[i]); end
        end
        drive(32'h9, DM_BYTE, 1'b1, 32'h00000012);
        tick();
        drive(32'h8, DM_WORD, 1'b0, 32'h0);
        n_checks++;
        if (rdata !== 32'h889912BB) begin n_fail++; $display("[TB] FAIL sb_merge: got %h required 889912bb", rdata); end
        drive(32'hA, DM_HALF, 1'b1, 32'h00003456);
        tick();
        drive(32'h8, DM_WORD, 1'b0, 32'h0);
        n_checks++;
        if (rdata !== 32'h345612BB) begin n_fail++; $display("[TB] FAIL sh_merge: got %h required 345612bb", rdata); end
    endtask

    task automatic test_errors();
        drive(32'h6, DM_WORD, 1'b1, 32'hDEADBEEF);
        n_checks++;
        if (access_err !== 1'b1) begin n_fail++; $display("[TB] FAIL misalign_err: got %b required 1", access_err); end
        tick();
        n_checks++;
        if (err_sticky !== 1'b1 || err_addr !== 32'h6)
            begin n_fail++; $display("[TB] FAIL sticky_first: sticky=%b addr=%h required 1/00000006", err_sticky, err_addr); end
        drive(32'h4, DM_WORD, 1'b0, 32'h0);
        n_checks++;
        if (rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL no_partial_write: got %h required 0", rdata); end
        drive(32'h3000, DM_WORD, 1'b0, 32'h0);
        n_checks++;
        if (rdata !== 32'h0 || access_err !== 1'b1)
            begin n_fail++; $display("[TB] FAIL oor_load: got %h err=%b required 0/1", rdata, access_err); end
        tick();
        n_checks++;
        if (err_addr !== 32'h6) begin n_fail++; $display("[TB] FAIL first_error_wins: got %h required 00000006", err_addr); end
        drive(32'h2FFF, DM_BYTE_U, 1'b0, 32'h0);
        n_checks++;
        if (access_err !== 1'b0) begin n_fail++; $display("[TB] FAIL top_byte_in_range: got %b required 0", access_err); end
        drive(32'h7, DM_NONE, 1'b1, 32'hFFFFFFFF);
        n_checks++;
        if (access_err !== 1'b0 || rdata !== 32'h0)
            begin n_fail++; $display("[TB] FAIL none_store: err=%b rdata=%h required 0/0", access_err, rdata); end
        tick();
        drive(32'h4, DM_WORD, 1'b0, 32'h0);
        n_checks++;
        if (rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL none_store_nowrite: got %h required 0", rdata); end
    endtask

    task automatic test_back_to_back();
        drive(32'h10, DM_WORD, 1'b1, 32'hCAFEF00D);
        n_checks++;
        if (rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL no_bypass: got %h required 0", rdata); end
        tick();
        drive(32'h10, DM_WORD, 1'b0, 32'h0);
        n_checks++;
        if (rdata !== 32'hCAFEF00D) begin n_fail++; $display("[TB] FAIL store_visible: got %h required cafef00d", rdata); end
    endtask

    task automatic test_reset_midcycle();
        drive(32'h14, DM_WORD, 1'b1, 32'h11223344);
        reset = 1'b0;
        m_clear();
        #1;
        n_checks++;
        if (err_sticky !== 1'b0 || err_addr !== 32'h0)
            begin n_fail++; $display("[TB] FAIL async_reset_regs: sticky=%b addr=%h required 0/0", err_sticky, err_addr); end
        mem_write = 1'b0;
        addr      = 32'h10;
        #1;
        n_checks++;
        if (rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL async_reset_array: got %h required 0", rdata); end
        @(posedge clk);
        #1 reset = 1'b1;
        drive(32'h14, DM_WORD, 1'b0, 32'h0);
        n_checks++;
        if (rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL store_discarded: got %h required 0", rdata); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [2:0]  op;
        logic        we;
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            case ($urandom_range(0, 3))
                0:       a = 32'h2FF0 + 32'($urandom_range(0, 31));
                default: a = 32'($urandom_range(0, 63));
            endcase
            op = 3'($urandom_range(0, 5));
            we = ($urandom_range(0, 2) == 0);
            pc = 32'($urandom);
            drive(a, op, we, 32'($urandom));
            n_checks++;
            if (rdata !== m_load(a, op) || access_err !== m_err(a, op))
                begin n_fail++; $display("[TB] FAIL rand_access[%0d] a=%h op=%0d: rdata=%h err=%b required %h/%b",
                                         i, a, op, rdata, access_err, m_load(a, op), m_err(a, op)); end
            tick();
            n_checks++;
            if (err_sticky !== m_sticky || err_addr !== m_err_addr)
                begin n_fail++; $display("[TB] FAIL rand_sticky[%0d]: sticky=%b addr=%h required %b/%h",
                                         i, err_sticky, err_addr, m_sticky, m_err_addr); end
        end
    endtask

    initial begin
        reset     = 1'b1;
        pc        = 32'h0;
        addr      = 32'h0;
        wdata     = 32'h0;
        mem_write = 1'b0;
        dm_op     = DM_NONE;
        test_reset();
        test_loads_stores();
        test_errors();
        test_back_to_back();
        test_reset_midcycle();
        do_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
